// File: rtl/clock_weekday_pkg.sv
// rtl/clock_weekday_pkg.sv - shared encodings, tables and helpers for the weekday sequencer
package clock_weekday_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIV12,
    S_SUM,
    S_DIV7A,
    S_DIFF,
    S_DIV7B,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    SUN = 3'd0,
    MON = 3'd1,
    TUE = 3'd2,
    WED = 3'd3,
    THU = 3'd4,
    FRI = 3'd5,
    SAT = 3'd6
  } weekday_t;

  // Reported when the date fails validation (outside the SUN..SAT range).
  localparam logic [2:0] WD_INVALID = 3'd7;

  localparam logic [3:0] DIV12 = 4'd12;
  localparam logic [3:0] DIV7  = 4'd7;

  // Two BCD digits to binary: tens*10 + units.
  function automatic logic [7:0] bcd2bin(input logic [3:0] tens, input logic [3:0] units);
    return ({4'd0, tens} << 3) + ({4'd0, tens} << 1) + {4'd0, units};
  endfunction

  // Century anchor code, indexed by century mod 4.
  function automatic logic [2:0] century_code(input logic [1:0] c);
    case (c)
      2'd0:    return 3'd2;
      2'd1:    return 3'd0;
      2'd2:    return 3'd5;
      default: return 3'd3;
    endcase
  endfunction

  // Day-of-month that falls on the doomsday; 0 for an out-of-range month.
  function automatic logic [4:0] doomsday_of_month(input logic [7:0] m, input logic leap);
    case (m)
      8'd1:    return 5'd3 + {4'd0, leap};
      8'd2:    return 5'd28 + {4'd0, leap};
      8'd3:    return 5'd14;
      8'd4:    return 5'd4;
      8'd5:    return 5'd9;
      8'd6:    return 5'd6;
      8'd7:    return 5'd11;
      8'd8:    return 5'd8;
      8'd9:    return 5'd5;
      8'd10:   return 5'd10;
      8'd11:   return 5'd7;
      8'd12:   return 5'd12;
      default: return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/clock_iter_divider.sv
// rtl/clock_iter_divider.sv - iterative repeated-subtraction divide/remainder unit
module clock_iter_divider #(
  parameter int DIV_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [DIV_W-1:0] dividend,
  input  logic [3:0]       divisor,
  output logic             rdy,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder
);

  logic [DIV_W-1:0] divisor_ext;

  // Zero-extend the divisor; a zero divisor reports ready at once so it can never stall.
  always_comb begin
    divisor_ext = {{(DIV_W-4){1'b0}}, divisor};
    rdy         = (remainder < divisor_ext) || (divisor == 4'd0);
  end

  // Load on go, otherwise subtract one divisor per cycle until the remainder drops below it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remainder <= '0;
      quotient  <= '0;
    end else if (go) begin
      remainder <= dividend;
      quotient  <= '0;
    end else if (!rdy) begin
      remainder <= remainder - divisor_ext;
      quotient  <= quotient + 1'b1;
    end
  end

endmodule

// File: rtl/clock_weekday_sequencer.sv
// rtl/clock_weekday_sequencer.sv - doomsday weekday FSM; optional CLOCK_WEEKDAY_DATE_CHECK_EN adds date_err
module clock_weekday_sequencer
  import clock_weekday_pkg::*;
#(
  parameter int DIV_W = 7
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       Is_Leap_Year,
  input  logic [3:0] clock_day,
  input  logic [3:0] clock_10day,
  input  logic [3:0] clock_1month,
  input  logic [3:0] clock_10month,
  input  logic [3:0] clock_year,
  input  logic [3:0] clock_decade,
  input  logic [3:0] clock_century,
  input  logic [3:0] clock_millenia,
  output logic       busy,
  output logic       done,
  output logic [2:0] weekday
`ifdef CLOCK_WEEKDAY_DATE_CHECK_EN
  ,
  output logic       date_err
`endif
);

  state_t state, next_state;

  logic [3:0] cap_day, cap_10day, cap_1month, cap_10month;
  logic [3:0] cap_year, cap_decade, cap_century, cap_millenia;
  logic       cap_leap;
  logic [1:0] c_r;
  logic [7:0] m_r, d_r;

  logic [7:0] m_in, d_in;
  logic [DIV_W-1:0] y_lo_in;
  logic [8:0] s_full, t_full;

  logic             div_go, div_rdy;
  logic [DIV_W-1:0] div_dividend, div_quotient, div_remainder;
  logic [3:0]       div_divisor;

  clock_iter_divider #(.DIV_W(DIV_W)) u_div (
    .clk       (CLK),
    .rst       (RST),
    .go        (div_go),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .rdy       (div_rdy),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  // BCD->binary conversion of the captured operands and the SUM / DIFF arithmetic.
  always_comb begin
    m_in    = bcd2bin(cap_10month, cap_1month);
    d_in    = bcd2bin(cap_10day, cap_day);
    y_lo_in = DIV_W'(bcd2bin(cap_decade, cap_year));
    s_full  = 9'(century_code(c_r)) + 9'(div_quotient) + 9'(div_remainder)
            + 9'(div_remainder >> 2);
    t_full  = 9'(div_remainder) + {1'b0, d_r} + 9'd35 - 9'(doomsday_of_month(m_r, cap_leap));
  end

`ifdef CLOCK_WEEKDAY_DATE_CHECK_EN
  logic date_ok;

  // Every digit must be decimal and the month/day must lie in their calendar ranges.
  always_comb begin
    date_ok = (cap_day <= 4'd9) && (cap_10day <= 4'd9) && (cap_1month <= 4'd9) &&
              (cap_10month <= 4'd9) && (cap_year <= 4'd9) && (cap_decade <= 4'd9) &&
              (cap_century <= 4'd9) && (cap_millenia <= 4'd9) &&
              (m_in >= 8'd1) && (m_in <= 8'd12) && (d_in >= 8'd1) && (d_in <= 8'd31);
  end
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next state and divider operand mux; each go loads the divider on the edge entering a DIV state.
  always_comb begin
    next_state   = state;
    div_go       = 1'b0;
    div_dividend = '0;
    div_divisor  = DIV7;
    case (state)
      S_IDLE:  if (start) next_state = S_LOAD;
      S_LOAD: begin
        div_go       = 1'b1;
        div_dividend = y_lo_in;
        div_divisor  = DIV12;
        next_state   = S_DIV12;
`ifdef CLOCK_WEEKDAY_DATE_CHECK_EN
        if (!date_ok) begin
          div_go     = 1'b0;
          next_state = S_DONE;
        end
`endif
      end
      S_DIV12: begin
        div_divisor = DIV12;
        if (div_rdy) next_state = S_SUM;
      end
      S_SUM: begin
        div_go       = 1'b1;
        div_dividend = DIV_W'(s_full);
        next_state   = S_DIV7A;
      end
      S_DIV7A: if (div_rdy) next_state = S_DIFF;
      S_DIFF: begin
        div_go       = 1'b1;
        div_dividend = DIV_W'(t_full);
        next_state   = S_DIV7B;
      end
      S_DIV7B: if (div_rdy) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Operand capture at start, binary operand registers in LOAD, result register on DIV7B exit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cap_day      <= '0;
      cap_10day    <= '0;
      cap_1month   <= '0;
      cap_10month  <= '0;
      cap_year     <= '0;
      cap_decade   <= '0;
      cap_century  <= '0;
      cap_millenia <= '0;
      cap_leap     <= 1'b0;
      c_r          <= '0;
      m_r          <= '0;
      d_r          <= '0;
      weekday      <= '0;
`ifdef CLOCK_WEEKDAY_DATE_CHECK_EN
      date_err     <= 1'b0;
`endif
    end else begin
      if (state == S_IDLE && start) begin
        cap_day      <= clock_day;
        cap_10day    <= clock_10day;
        cap_1month   <= clock_1month;
        cap_10month  <= clock_10month;
        cap_year     <= clock_year;
        cap_decade   <= clock_decade;
        cap_century  <= clock_century;
        cap_millenia <= clock_millenia;
        cap_leap     <= Is_Leap_Year;
`ifdef CLOCK_WEEKDAY_DATE_CHECK_EN
        date_err     <= 1'b0;
`endif
      end
      if (state == S_LOAD) begin
        c_r <= 2'(bcd2bin(cap_millenia, cap_century));
        m_r <= m_in;
        d_r <= d_in;
`ifdef CLOCK_WEEKDAY_DATE_CHECK_EN
        if (!date_ok) begin
          weekday  <= WD_INVALID;
          date_err <= 1'b1;
        end
`endif
      end
      if (state == S_DIV7B && div_rdy) weekday <= div_remainder[2:0];
    end
  end

  // Handshake outputs decode directly from the state so reset clears them at once.
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

endmodule

// File: tb/tb_clock_weekday_sequencer.sv
// tb/tb_clock_weekday_sequencer.sv - directed self-checking bench for clock_weekday_sequencer
module tb_clock_weekday_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic       Is_Leap_Year = 1'b0;
  logic [3:0] clock_day = '0, clock_10day = '0, clock_1month = '0, clock_10month = '0;
  logic [3:0] clock_year = '0, clock_decade = '0, clock_century = '0, clock_millenia = '0;
  logic       busy, done;
  logic [2:0] weekday;
`ifdef CLOCK_WEEKDAY_DATE_CHECK_EN
  logic       date_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  clock_weekday_sequencer #(.DIV_W(7)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .start          (start),
    .Is_Leap_Year   (Is_Leap_Year),
    .clock_day      (clock_day),
    .clock_10day    (clock_10day),
    .clock_1month   (clock_1month),
    .clock_10month  (clock_10month),
    .clock_year     (clock_year),
    .clock_decade   (clock_decade),
    .clock_century  (clock_century),
    .clock_millenia (clock_millenia),
    .busy           (busy),
    .done           (done),
    .weekday        (weekday)
`ifdef CLOCK_WEEKDAY_DATE_CHECK_EN
    ,
    .date_err       (date_err)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_date(input logic [15:0] yr, input logic [7:0] mo, input logic [7:0] dy,
                          input logic leap);
    clock_millenia = yr[15:12];
    clock_century  = yr[11:8];
    clock_decade   = yr[7:4];
    clock_year     = yr[3:0];
    clock_10month  = mo[7:4];
    clock_1month   = mo[3:0];
    clock_10day    = dy[7:4];
    clock_day      = dy[3:0];
    Is_Leap_Year   = leap;
  endtask

  // Edges counted after the start-sampling edge until done is seen; bounded.
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 300) begin
      @(posedge CLK);
      #1;
      cnt++;
    end
  endtask

  task automatic run_date(input string tag, input logic [15:0] yr, input logic [7:0] mo,
                          input logic [7:0] dy, input logic leap, input int exp_wd,
                          input int exp_lat);
    int cnt;
    set_date(yr, mo, dy, leap);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    set_date(16'h0000, 8'h00, 8'h00, ~leap);
    check({tag, "_busy_after_start"}, busy, 1);
`ifdef CLOCK_WEEKDAY_DATE_CHECK_EN
    check({tag, "_date_err_cleared"}, date_err, 0);
`endif
    wait_done(cnt);
    check({tag, "_latency"}, cnt, exp_lat);
    check({tag, "_weekday"}, weekday, exp_wd);
    check({tag, "_busy_in_done"}, busy, 1);
    @(posedge CLK);
    #1;
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_weekday_held"}, weekday, exp_wd);
  endtask

  initial begin
    int cnt;
    int ndone;

    repeat (2) @(posedge CLK);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_weekday", weekday, 0);
`ifdef CLOCK_WEEKDAY_DATE_CHECK_EN
    check("reset_date_err", date_err, 0);
`endif
    RST = 1'b0;
    @(posedge CLK);
    #1;

    run_date("d20240101", 16'h2024, 8'h01, 8'h01, 1'b1, 1, 13);
    run_date("d20000229", 16'h2000, 8'h02, 8'h29, 1'b1, 2, 11);
    run_date("d19991231", 16'h1999, 8'h12, 8'h31, 1'b0, 5, 23);
    run_date("d21000301", 16'h2100, 8'h03, 8'h01, 1'b0, 1, 9);

    // start re-pulsed while busy must be ignored: exactly one done.
    set_date(16'h2024, 8'h01, 8'h01, 1'b1);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #1;
      if (done) ndone++;
    end
    check("repulse_single_done", ndone, 1);
    check("repulse_weekday", weekday, 1);

    // start held through DONE: ignored in DONE, accepted in the following IDLE cycle.
    set_date(16'h2024, 8'h01, 8'h01, 1'b1);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    wait_done(cnt);
    check("b2b_first_done", done, 1);
    set_date(16'h1999, 8'h12, 8'h31, 1'b0);
    start = 1'b1;
    @(posedge CLK);
    #1;
    check("b2b_ignored_in_done", busy, 0);
    @(posedge CLK);
    #1;
    start = 1'b0;
    check("b2b_accepted_in_idle", busy, 1);
    wait_done(cnt);
    check("b2b_latency", cnt, 23);
    check("b2b_weekday", weekday, 5);
    @(posedge CLK);
    #1;

    // Reset in the middle of DIV7A (edges 11..12 for 1999-12-31).
    set_date(16'h1999, 8'h12, 8'h31, 1'b0);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (11) @(posedge CLK);
    #1;
    check("midreset_was_busy", busy, 1);
    RST = 1'b1;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_weekday", weekday, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    check("midreset_no_done", done, 0);
    run_date("after_reset", 16'h2000, 8'h02, 8'h29, 1'b1, 2, 11);

`ifdef CLOCK_WEEKDAY_DATE_CHECK_EN
    set_date(16'h2024, 8'h13, 8'h01, 1'b1);
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    wait_done(cnt);
    check("bad_month_latency", cnt, 1);
    check("bad_month_date_err", date_err, 1);
    check("bad_month_weekday", weekday, 7);
    @(posedge CLK);
    #1;
    run_date("valid_after_err", 16'h2024, 8'h01, 8'h01, 1'b1, 1, 13);
    check("date_err_clear", date_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
